// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// A shared 2*WIDTH accumulator is used for both shift-add multiply and restoring divide.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operandA,
    input  logic [WIDTH-1:0] operandB,
    input  logic             mtWriteHi,
    input  logic             mtWriteLo,
    input  logic [WIDTH-1:0] mtValue,
    output logic             busy,
    output logic             done,
    output logic             divByZero,
    output logic [WIDTH-1:0] hiValue,
    output logic [WIDTH-1:0] loValue,
    output logic [1:0]       dbgState
);

    // Handshake: start (with op/operands) is taken on a rising edge only while busy=0;
    // done pulses for one cycle in the first cycle the new HI/LO are visible.

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    state_t             r_state;
    logic [CW-1:0]      r_cnt;
    logic [1:0]         r_op;
    logic               r_signA;
    logic               r_signB;
    logic               r_bZero;
    logic [WIDTH-1:0]   r_origA;
    logic [WIDTH-1:0]   r_opnd;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_busy;
    logic               r_done;
    logic               r_dbz;

    logic [WIDTH-1:0]   w_absA;
    logic [WIDTH-1:0]   w_absB;
    logic [WIDTH:0]     w_mulSum;
    logic [2*WIDTH-1:0] w_mulNext;
    logic [WIDTH:0]     w_remSh;
    logic [WIDTH:0]     w_diff;
    logic               w_ge;
    logic [2*WIDTH-1:0] w_divNext;
    logic               w_negRes;
    logic [2*WIDTH-1:0] w_prodFix;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_hiRes;
    logic [WIDTH-1:0]   w_loRes;

    assign w_absA = (op[0] && operandA[WIDTH-1]) ? -operandA : operandA;
    assign w_absB = (op[0] && operandB[WIDTH-1]) ? -operandB : operandB;

    // Multiply step: add multiplicand into the upper half when the low bit is set, then shift right.
    assign w_mulSum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});
    assign w_mulNext = {w_mulSum, r_acc[WIDTH-1:1]};

    // Divide step: remainder/quotient pair shifts left; subtract divisor when it fits.
    assign w_remSh   = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_diff    = w_remSh - {1'b0, r_opnd};
    assign w_ge      = (w_remSh >= {1'b0, r_opnd});
    assign w_divNext = w_ge ? {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1}
                            : {w_remSh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};

    assign w_negRes  = r_op[0] && (r_signA != r_signB);
    assign w_prodFix = w_negRes ? -r_acc : r_acc;
    assign w_quot    = w_negRes ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_rem     = (r_op[0] && r_signA) ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

    always_comb begin
        w_hiRes = w_prodFix[2*WIDTH-1:WIDTH];
        w_loRes = w_prodFix[WIDTH-1:0];
        if (r_op[1]) begin
            if (r_bZero) begin
                w_hiRes = r_origA;
                w_loRes = {WIDTH{1'b1}};
            end else begin
                w_hiRes = w_rem;
                w_loRes = w_quot;
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_op    <= 2'b00;
            r_signA <= 1'b0;
            r_signB <= 1'b0;
            r_bZero <= 1'b0;
            r_origA <= '0;
            r_opnd  <= '0;
            r_acc   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_dbz   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_dbz  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_RUN;
                        r_busy  <= 1'b1;
                        r_op    <= op;
                        r_signA <= operandA[WIDTH-1];
                        r_signB <= operandB[WIDTH-1];
                        r_bZero <= (operandB == '0);
                        r_origA <= operandA;
                        r_cnt   <= '0;
                        r_acc   <= op[1] ? {{WIDTH{1'b0}}, w_absA} : {{WIDTH{1'b0}}, w_absB};
                        r_opnd  <= op[1] ? w_absB : w_absA;
                    end else begin
                        if (mtWriteHi) r_hi <= mtValue;
                        if (mtWriteLo) r_lo <= mtValue;
                    end
                end
                ST_RUN: begin
                    r_acc <= r_op[1] ? w_divNext : w_mulNext;
                    if (r_cnt == LAST_ITER) r_state <= ST_FIX;
                    else                    r_cnt   <= r_cnt + 1'b1;
                end
                ST_FIX: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_dbz   <= r_op[1] & r_bZero;
                    r_hi    <= w_hiRes;
                    r_lo    <= w_loRes;
                    r_cnt   <= '0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign divByZero = r_dbz;
    assign hiValue   = r_hi;
    assign loValue   = r_lo;
    assign dbgState  = r_state;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: table vectors, hand-written busy/MT/reset sequences,
// and randomized operations compared against an arithmetic reference model.
module tb_mult_div_unit;

    localparam int W = 32;

    logic         clk;
    logic         resetN;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] operandA;
    logic [W-1:0] operandB;
    logic         mtWriteHi;
    logic         mtWriteLo;
    logic [W-1:0] mtValue;
    logic         busy;
    logic         done;
    logic         divByZero;
    logic [W-1:0] hiValue;
    logic [W-1:0] loValue;
    logic [1:0]   dbgState;

    mult_div_unit #(.WIDTH(W)) dut (
        .clk(clk), .resetN(resetN), .start(start), .op(op),
        .operandA(operandA), .operandB(operandB),
        .mtWriteHi(mtWriteHi), .mtWriteLo(mtWriteLo), .mtValue(mtValue),
        .busy(busy), .done(done), .divByZero(divByZero),
        .hiValue(hiValue), .loValue(loValue), .dbgState(dbgState)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    logic [64:0] exp_q[$];   // {divByZero, HI, LO}
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [64:0] ref_model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            2'b00: begin
                p = {32'b0, a} * {32'b0, b};
                return {1'b0, p};
            end
            2'b01: begin
                p = 64'(sa * sb);
                return {1'b0, p};
            end
            default: begin
                if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
                if (o == 2'b10) return {1'b0, a % b, a / b};
                q = sa / sb;
                r = sa % sb;
                return {1'b0, r[31:0], q[31:0]};
            end
        endcase
    endfunction

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    // Drives one operation; optionally injects a DIVU start + MTHI at cycle inj_cycle,
    // or holds mtWriteLo together with start. Pops the expected result from exp_q.
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int inj_cycle, input logic mt_with_start, input string name);
        logic [64:0] exp;
        logic [W-1:0] hold_hi, hold_lo;
        bit busy_ok, stable_ok, seen;
        int lat;
        hold_hi = m_hi;
        hold_lo = m_lo;
        start = 1'b1; op = o; operandA = a; operandB = b;
        mtWriteLo = mt_with_start; mtValue = 32'h5555_5555;
        busy_ok = 1; stable_ok = 1; seen = 0; lat = 0;
        for (int n = 1; n <= 40 && !seen; n++) begin
            @(posedge clk); #1;
            start = 1'b0; mtWriteLo = 1'b0; mtWriteHi = 1'b0;
            if (n == inj_cycle) begin
                start = 1'b1; op = 2'b10; operandA = 9; operandB = 3;
                mtWriteHi = 1'b1; mtValue = 32'h0000_AAAA;
            end
            if (done === 1'b1) begin
                seen = 1;
                lat = n;
            end else begin
                if (busy !== 1'b1) busy_ok = 0;
                if (hiValue !== hold_hi || loValue !== hold_lo) stable_ok = 0;
            end
        end
        start = 1'b0; mtWriteHi = 1'b0; mtWriteLo = 1'b0;
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 65'h0;
        check({name, " latency"}, 64'(lat), 64'd34);
        check({name, " busy window"}, 64'(busy_ok), 64'd1);
        check({name, " hi/lo stable while busy"}, 64'(stable_ok), 64'd1);
        if (seen) begin
            check({name, " busy at done"}, 64'(busy), 64'd0);
            check({name, " HI"}, 64'(hiValue), 64'(exp[63:32]));
            check({name, " LO"}, 64'(loValue), 64'(exp[31:0]));
            check({name, " divByZero"}, 64'(divByZero), 64'(exp[64]));
        end
        m_hi = exp[63:32];
        m_lo = exp[31:0];
    endtask

    task automatic mt_write(input logic wh, input logic wl, input logic [W-1:0] v);
        mtWriteHi = wh; mtWriteLo = wl; mtValue = v;
        @(posedge clk); #1;
        mtWriteHi = 1'b0; mtWriteLo = 1'b0;
        if (wh) m_hi = v;
        if (wl) m_lo = v;
        check("MT HI", 64'(hiValue), 64'(m_hi));
        check("MT LO", 64'(loValue), 64'(m_lo));
    endtask

    initial begin
        logic [64:0] e;
        logic [1:0]  ro;
        logic [W-1:0] ra, rb;

        vecs[0] = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
        vecs[1] = '{2'b01, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
        vecs[2] = '{2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        vecs[3] = '{2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
        vecs[4] = '{2'b10, 32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF, 1'b1};
        vecs[5] = '{2'b10, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, 1'b0};
        vecs[6] = '{2'b11, 32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1};
        vecs[7] = '{2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};

        resetN = 1'b0; start = 1'b0; op = 2'b00; operandA = '0; operandB = '0;
        mtWriteHi = 1'b0; mtWriteLo = 1'b0; mtValue = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset divByZero", 64'(divByZero), 64'd0);
        check("reset HI", 64'(hiValue), 64'd0);
        check("reset LO", 64'(loValue), 64'd0);
        @(negedge clk);
        resetN = 1'b1;
        @(posedge clk); #1;

        // Start and MTHI while busy must both be ignored
        exp_q.push_back({1'b0, 32'h0, 32'h0000_001E});
        run_op(2'b00, 32'd5, 32'd6, 10, 1'b0, "busy-window MULTU 5x6");

        for (int i = 0; i < 8; i++) begin
            exp_q.push_back({vecs[i].dbz, vecs[i].hi, vecs[i].lo});
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, 0, 1'b0, $sformatf("vec%0d", i));
        end

        mt_write(1'b0, 1'b1, 32'h0000_1234);
        mt_write(1'b1, 1'b1, 32'h0000_CAFE);

        // start has priority over a simultaneous MTLO
        exp_q.push_back({1'b0, 32'h0, 32'h6});
        run_op(2'b00, 32'd2, 32'd3, 0, 1'b1, "start+MTLO");

        for (int i = 0; i < 24; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = pick_operand();
            rb = pick_operand();
            e = ref_model(ro, ra, rb);
            exp_q.push_back(e);
            run_op(ro, ra, rb, 0, 1'b0, $sformatf("rand%0d op%0d %h %h", i, ro, ra, rb));
        end

        // Asynchronous reset mid-RUN
        mt_write(1'b1, 1'b1, 32'hDEAD_BEEF);
        start = 1'b1; op = 2'b01; operandA = 32'hFFFF_FFFD; operandB = 32'd7;
        for (int n = 1; n <= 15; n++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        #2 resetN = 1'b0;
        #1;
        check("async reset busy", 64'(busy), 64'd0);
        check("async reset done", 64'(done), 64'd0);
        check("async reset HI", 64'(hiValue), 64'd0);
        check("async reset LO", 64'(loValue), 64'd0);
        check("async reset state", 64'(dbgState), 64'd0);
        @(negedge clk);
        resetN = 1'b1;
        m_hi = '0;
        m_lo = '0;
        @(posedge clk); #1;
        exp_q.push_back({1'b0, 32'h0, 32'h6});
        run_op(2'b00, 32'd2, 32'd3, 0, 1'b0, "post-reset MULTU 2x3");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
